tff_toggle_arbiter: RTL and testbench
=====================================

Name: tff_toggle_arbiter

Overview:
Round-robin arbiter that shares one bank of WIDTH T flip-flops among NREQ requesters. Each requester asks for the bank with a req/gnt/ack handshake and supplies a toggle mask. While a requester holds the grant, the block applies that mask once to the shared register: every bit where the mask is 1 toggles, every other bit holds. The block sits between the client FSMs and the toggle register, and it owns that register.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of T flip-flops in the shared bank.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request level; must stay high until the matching ack.
- mask  in  NREQ*WIDTH  toggle masks; requester i drives bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, registered.
- ack  out  NREQ  one-hot, single-cycle pulse marking that the toggle has been applied.
- q  out  WIDTH  shared T flip-flop bank state.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE, q=0, gnt=0, ack=0, busy=0, ptr=0.
  - The latched winner index and latched mask are cleared.
  - Any transaction in flight is discarded: no ack is issued and q is not updated.
- States: IDLE, GRANT, APPLY, RELEASE.
- Winner selection:
  - The winner is the first requester with req high, searching from index ptr upward and wrapping modulo NREQ.
  - ptr holds the index after the last requester served.
- IDLE:
  - If req!=0 at a clock edge: latch the winner index w, set gnt[w]=1, go to GRANT.
  - Otherwise stay in IDLE with gnt=0.
- GRANT (one cycle):
  - If req[w]=1: latch mask slice w, go to APPLY.
  - If req[w]=0 (abort): clear gnt, set ptr=(w+1) mod NREQ, go to IDLE; no ack is issued and q is unchanged.
- APPLY (one cycle):
  - q <= q XOR latched mask.
  - ack[w]=1 for exactly the following cycle.
  - Go to RELEASE.
  - The mask is sampled only in GRANT; mask changes afterwards are ignored.
- RELEASE:
  - gnt[w] stays high while req[w]=1.
  - When req[w]=0 is sampled: gnt=0, ptr=(w+1) mod NREQ, go to IDLE.
- Latency: req is first sampled high at edge E0. Then gnt rises after E0, q updates and ack pulses after E0+2, and the earliest next grant follows release by one edge.
- Boundary conditions:
  - A mask of all zeros still produces a full transaction with ack; q is unchanged.
  - A mask of all ones inverts q.
  - ptr wraps from NREQ-1 to 0.
  - Changes on other requesters' req during a transaction are ignored until IDLE.
  - At most one gnt bit and at most one ack bit are high at any time.
  - q is modified only in APPLY.

Decomposition:
- Package tff_arb_pkg holds:
  - state encoding localparams (IDLE=0, GRANT=1, APPLY=2, RELEASE=3) and state width 2;
  - defaults for NREQ and WIDTH.
- Sub-module tff_rr_picker: combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: valid and winner index.
  - Instantiated once.
- The rest (FSM, latches, q register) lives in tff_toggle_arbiter.

Test Plan (NREQ=4, WIDTH=8):
1. Reset: hold rst=1 for 2 cycles while req=1111 -> q=00, gnt=0000, ack=0000, busy=0. Then release rst -> the first grant goes to requester 0.
2. Single requester, toggle twice:
   - req=0010, mask1=0x0F -> gnt=0010 one edge after sampling; ack=0010 pulses for 1 cycle two edges later; q=0x0F.
   - Drop req, then repeat the same transaction -> q=0x00.
3. All requesters at once: req=1111 with masks 0x01/0x02/0x04/0x08, each requester dropping req after its ack -> grant order 0,1,2,3; q=0x0F; no overlapping gnt bits.
4. Fairness: after serving requester 2 (ptr=3), assert req=0101 -> requester 0 is granted before requester 2; requester 3 is never granted.
5. Abort: req=0001, mask0=0xFF, with req dropped during GRANT -> no ack, q unchanged, busy=0 on the next cycle. The next request from 1111 is granted to requester 1.
6. Reset mid-APPLY: assert rst asynchronously while in APPLY with q=0x3C -> q=00 and gnt=0 immediately; no ack is observed.

Source files
------------

// File: rtl/tff_arb_pkg.sv
// Shared definitions for the round-robin toggle-bank arbiter.
// State encoding and default geometry.
package tff_arb_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 8;
   localparam int STATE_W   = 2;

   localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [STATE_W-1:0] ST_GRANT   = 2'd1;
   localparam logic [STATE_W-1:0] ST_APPLY   = 2'd2;
   localparam logic [STATE_W-1:0] ST_RELEASE = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = ST_IDLE,
      S_GRANT   = ST_GRANT,
      S_APPLY   = ST_APPLY,
      S_RELEASE = ST_RELEASE
   } state_e;

endpackage

// File: rtl/tff_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo NREQ.
module tff_rr_picker #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic            valid_o,
   output logic [IW-1:0]   win_o
);

   localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [IW:0]       off;
   logic [IW:0]       sum;

   // Rotate so that bit 0 of rot is requester ptr.
   assign dbl = {req_i, req_i} >> ptr_i;
   assign rot = dbl[NREQ-1:0];

   always_comb begin
      valid_o = 1'b0;
      off     = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (rot[k]) begin
            valid_o = 1'b1;
            off     = (IW+1)'(k);
         end
      end
      sum = {1'b0, ptr_i} + off;
      if (sum >= NREQ_W) begin
         sum = sum - NREQ_W;
      end
      win_o = sum[IW-1:0];
   end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Shares one bank of T flip-flops among NREQ clients; the granted
// client's mask is XORed into the bank once per transaction.
module tff_toggle_arbiter
   import tff_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] mask,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      q,
   output logic                  busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW-1:0] LAST = IW'(NREQ-1);

   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     win_q, win_d;
   logic [WIDTH-1:0]  msk_q, msk_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [WIDTH-1:0]  tq_q, tq_d;

   logic              pick_v;
   logic [IW-1:0]     pick_w;
   logic [NREQ-1:0]   pick_oh;
   logic [WIDTH-1:0]  sel_m;
   logic [IW-1:0]     nxt_ptr;
   logic              req_w;

   tff_rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .valid_o (pick_v),
      .win_o   (pick_w)
   );

   always_comb begin
      pick_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         pick_oh[i] = (pick_w == IW'(i));
      end
   end

   always_comb begin
      sel_m = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_q == IW'(i)) begin
            sel_m = mask[i*WIDTH +: WIDTH];
         end
      end
   end

   // gnt_q is one-hot on the winner whenever the winner matters.
   assign req_w   = |(req & gnt_q);
   assign nxt_ptr = (win_q == LAST) ? '0 : win_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      msk_d   = msk_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      tq_d    = tq_q;
      unique case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (pick_v) begin
               win_d   = pick_w;
               gnt_d   = pick_oh;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (req_w) begin
               msk_d   = sel_m;
               state_d = S_APPLY;
            end else begin
               gnt_d   = '0;
               ptr_d   = nxt_ptr;
               state_d = S_IDLE;
            end
         end
         S_APPLY: begin
            tq_d    = tq_q ^ msk_q;
            ack_d   = gnt_q;
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!req_w) begin
               gnt_d   = '0;
               ptr_d   = nxt_ptr;
               state_d = S_IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         msk_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         tq_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         msk_q   <= msk_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         tq_q    <= tq_d;
      end
   end

   assign gnt  = gnt_q;
   assign ack  = ack_q;
   assign q    = tq_q;
   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed plus randomized bench for tff_toggle_arbiter against a
// transaction-level model (winner search, XOR accumulate, pointer).
module tb_tff_toggle_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] mask;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic [W-1:0]   q;
   logic           busy;

   int n_chk;
   int n_fail;

   logic [W-1:0] mk [N];
   logic [W-1:0] ref_q;
   int           ref_ptr;
   int           w;

   tff_toggle_arbiter #(
      .NREQ  (N),
      .WIDTH (W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .mask (mask),
      .gnt  (gnt),
      .ack  (ack),
      .q    (q),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
         chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      end
   end

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pack_masks();
      for (int i = 0; i < N; i++) mask[i*W +: W] = mk[i];
   endtask

   // One full transaction starting from IDLE with req already driven.
   task automatic serve(output int wo);
      int          ew;
      logic [W-1:0] m;
      pack_masks();
      ew = pick(req, ref_ptr);
      wo = ew;
      m  = mk[ew];
      step();
      chk("grant", 32'(gnt), 32'(1 << ew));
      chk("busy_grant", 32'(busy), 32'd1);
      chk("ack_early", 32'(ack), 32'd0);
      step();
      chk("q_hold", 32'(q), 32'(ref_q));
      chk("ack_apply", 32'(ack), 32'd0);
      mask[ew*W +: W] = ~m;
      step();
      ref_q = ref_q ^ m;
      chk("ack_pulse", 32'(ack), 32'(1 << ew));
      chk("q_update", 32'(q), 32'(ref_q));
      chk("gnt_hold", 32'(gnt), 32'(1 << ew));
      mask[ew*W +: W] = m;
      req[ew] = 1'b0;
      step();
      ref_ptr = (ew + 1) % N;
      chk("gnt_clear", 32'(gnt), 32'd0);
      chk("ack_single", 32'(ack), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      ref_q   = '0;
      ref_ptr = 0;
      for (int i = 0; i < N; i++) mk[i] = '0;
      rst  = 1'b1;
      req  = 4'b1111;
      mask = '0;

      // 1: reset with all requesters asking
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      mk[0] = 8'h00;
      serve(w);
      chk("first_winner", 32'(w), 32'd0);
      chk("zero_mask_q", 32'(q), 32'h00);
      req = '0;

      // 2: single requester toggles twice
      mk[1] = 8'h0F;
      req = 4'b0010;
      serve(w);
      chk("single_q1", 32'(q), 32'h0F);
      req = 4'b0010;
      serve(w);
      chk("single_q2", 32'(q), 32'h00);

      // all-ones mask inverts; ptr wraps 3 -> 0
      mk[3] = 8'hFF;
      req = 4'b1000;
      serve(w);
      chk("ones_invert", 32'(q), 32'hFF);
      req = 4'b1000;
      serve(w);
      chk("ones_back", 32'(q), 32'h00);

      // 3: all at once
      mk[0] = 8'h01;
      mk[1] = 8'h02;
      mk[2] = 8'h04;
      mk[3] = 8'h08;
      req = 4'b1111;
      for (int i = 0; i < N; i++) begin
         serve(w);
         chk("rr_order", 32'(w), 32'(i));
      end
      chk("all_q", 32'(q), 32'h0F);

      // 4: fairness after serving requester 2
      req = 4'b0100;
      serve(w);
      req = 4'b0101;
      serve(w);
      chk("fair_first", 32'(w), 32'd0);
      serve(w);
      chk("fair_second", 32'(w), 32'd2);

      // randomized rounds
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < N; i++) mk[i] = W'($urandom);
         req = N'($urandom_range(1, 15));
         while (req != '0) serve(w);
      end

      // 5: abort during GRANT
      mk[0] = 8'hFF;
      pack_masks();
      req = 4'b0001;
      chk("abort_pick", 32'(pick(req, ref_ptr)), 32'd0);
      step();
      chk("abort_gnt", 32'(gnt), 32'd1);
      req = '0;
      step();
      ref_ptr = 1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_gnt0", 32'(gnt), 32'd0);
      chk("abort_q", 32'(q), 32'(ref_q));
      step();
      chk("abort_noack", 32'(ack), 32'd0);
      req = 4'b1111;
      serve(w);
      chk("abort_next", 32'(w), 32'd1);
      req = '0;

      // 6: reset while in APPLY with q = 3C
      mk[2] = ref_q ^ 8'h3C;
      req = 4'b0100;
      serve(w);
      chk("pre_q", 32'(q), 32'h3C);
      mk[1] = W'($urandom);
      pack_masks();
      req = 4'b0010;
      step();
      step();
      chk("pre_rst_q", 32'(q), 32'h3C);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_q", 32'(q), 32'd0);
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      step();
      chk("arst_ack", 32'(ack), 32'd0);
      chk("arst_q2", 32'(q), 32'd0);
      req = '0;
      rst = 1'b0;
      ref_q = '0;
      ref_ptr = 0;
      step();
      chk("post_ack", 32'(ack), 32'd0);
      chk("post_q", 32'(q), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
